buzzer_sched: RTL and testbench

Schedules the clock's single buzzer among three alarm sources: alarm-time match, countdown-timer expiry and hourly chime. It latches requests, grants the buzzer by fixed priority, generates each source's blink/beep pattern from the 3 Hz strobe, and handles the user's stop and snooze buttons. It sits between the time/alarm comparators and the buzzer/LED output pin, and replaces a per-source buzzer driver.

---
 rtl/buzzer_sched_pkg.sv | 45 ++++
 rtl/buzzer_sched_if.sv | 34 +++
 rtl/buzzer_sched_rise_detect.sv | 25 ++
 rtl/buzzer_sched.sv | 155 +++++++++++++++
 tb/tb_buzzer_sched.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/buzzer_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : buzzer_sched_pkg
// Summary  : Source and state encodings shared by the buzzer scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package buzzer_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RING = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [1:0] c_SRC_NONE  = 2'd0;
    localparam logic [1:0] c_SRC_ALARM = 2'd1;
    localparam logic [1:0] c_SRC_TIMER = 2'd2;
    localparam logic [1:0] c_SRC_CHIME = 2'd3;

    localparam int c_TICKS_PER_SEC = 3;
    localparam int c_CNT_W         = 10;

    // Lowest pending bit wins: alarm, then timer, then chime.
    function automatic logic [1:0] pick_src(input logic [2:0] req);
        logic [1:0] src;
        src = c_SRC_NONE;
        if (req[0])      src = c_SRC_ALARM;
        else if (req[1]) src = c_SRC_TIMER;
        else if (req[2]) src = c_SRC_CHIME;
        return src;
    endfunction

    function automatic logic [2:0] src_mask(input logic [1:0] src);
        logic [2:0] mask;
        case (src)
            c_SRC_ALARM: mask = 3'b001;
            c_SRC_TIMER: mask = 3'b010;
            c_SRC_CHIME: mask = 3'b100;
            default:     mask = 3'b000;
        endcase
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/buzzer_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : buzzer_sched_if
// Summary  : Strobes, requests, buttons and buzzer outputs of the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface buzzer_sched_if;

    logic       tick_3hz;
    logic       tick_1hz;
    logic       req_alarm;
    logic       req_timer;
    logic       req_chime;
    logic       btn_stop;
    logic       btn_snooze;
    logic       buzzer;
    logic [1:0] active_src;
    logic [2:0] pending;
    logic       snoozed;

    modport master (
        output tick_3hz, tick_1hz, req_alarm, req_timer, req_chime,
               btn_stop, btn_snooze,
        input  buzzer, active_src, pending, snoozed
    );

    modport slave (
        input  tick_3hz, tick_1hz, req_alarm, req_timer, req_chime,
               btn_stop, btn_snooze,
        output buzzer, active_src, pending, snoozed
    );

endinterface
`default_nettype wire

// File: rtl/buzzer_sched_rise_detect.sv
`default_nettype none
// ============================================================================
// Module   : buzzer_sched_rise_detect
// Summary  : Registered rising-edge detector; a level high at reset release
//            counts as an edge.
// Revision : 1.0 - initial release
// ============================================================================
module buzzer_sched_rise_detect (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_din,
    output logic      o_rise
);

    logic r_prev;

    always_ff @(posedge clk) begin
        if (reset) r_prev <= 1'b0;
        else       r_prev <= i_din;
    end

    assign o_rise = i_din & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/buzzer_sched.sv
`default_nettype none
// ============================================================================
// Module   : buzzer_sched
// Summary  : Shares one buzzer between alarm, timer and hourly chime with
//            fixed priority, beep patterns, stop and snooze handling.
// Revision : 1.0 - initial release
// ============================================================================
module buzzer_sched
    import buzzer_sched_pkg::*;
#(
    parameter int ALARM_SECONDS  = 5,
    parameter int TIMER_SECONDS  = 5,
    parameter int CHIME_BEEPS    = 2,
    parameter int SNOOZE_SECONDS = 300
) (
    input  wire logic     clk,
    input  wire logic     reset,
    buzzer_sched_if.slave bus
);

    localparam logic [c_CNT_W-1:0] c_ALARM_LAST  = c_CNT_W'(c_TICKS_PER_SEC * ALARM_SECONDS - 1);
    localparam logic [c_CNT_W-1:0] c_TIMER_LAST  = c_CNT_W'(c_TICKS_PER_SEC * TIMER_SECONDS - 1);
    localparam logic [c_CNT_W-1:0] c_CHIME_LAST  = c_CNT_W'(2 * CHIME_BEEPS - 1);
    localparam logic [c_CNT_W-1:0] c_SNOOZE_LOAD = c_CNT_W'(SNOOZE_SECONDS);

    logic [2:0]         w_req;
    logic [2:0]         w_rise;
    logic [2:0]         w_accept;
    logic [1:0]         w_grant_src;
    logic [2:0]         w_grant_mask;
    logic [c_CNT_W-1:0] w_last;

    state_t             r_state,      w_state_nx;
    logic               r_buzzer,     w_buzzer_nx;
    logic [1:0]         r_src,        w_src_nx;
    logic [2:0]         r_pending,    w_pending_nx;
    logic               r_snoozed,    w_snoozed_nx;
    logic [c_CNT_W-1:0] r_tick_cnt,   w_tick_cnt_nx;
    logic [c_CNT_W-1:0] r_snooze_cnt, w_snooze_cnt_nx;

    assign w_req = {bus.req_chime, bus.req_timer, bus.req_alarm};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_rise
            buzzer_sched_rise_detect u_rise (
                .clk    (clk),
                .reset  (reset),
                .i_din  (w_req[gi]),
                .o_rise (w_rise[gi])
            );
        end
    endgenerate

    // r_src is NONE outside RING, so only the source actually ringing is masked.
    assign w_accept     = w_rise & ~src_mask(r_src);
    assign w_grant_src  = (r_state == ST_IDLE) ? pick_src(r_pending) : c_SRC_NONE;
    assign w_grant_mask = src_mask(w_grant_src);

    always_comb begin
        case (r_src)
            c_SRC_ALARM: w_last = c_ALARM_LAST;
            c_SRC_TIMER: w_last = c_TIMER_LAST;
            default:     w_last = c_CHIME_LAST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_buzzer     <= 1'b0;
            r_src        <= c_SRC_NONE;
            r_pending    <= 3'b000;
            r_snoozed    <= 1'b0;
            r_tick_cnt   <= '0;
            r_snooze_cnt <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_buzzer     <= w_buzzer_nx;
            r_src        <= w_src_nx;
            r_pending    <= w_pending_nx;
            r_snoozed    <= w_snoozed_nx;
            r_tick_cnt   <= w_tick_cnt_nx;
            r_snooze_cnt <= w_snooze_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx      = r_state;
        w_buzzer_nx     = r_buzzer;
        w_src_nx        = r_src;
        w_tick_cnt_nx   = r_tick_cnt;
        w_snoozed_nx    = r_snoozed;
        w_snooze_cnt_nx = r_snooze_cnt;
        w_pending_nx    = (r_pending & ~w_grant_mask) | w_accept;

        if (r_snoozed && bus.tick_1hz) begin
            w_snooze_cnt_nx = r_snooze_cnt - 1'b1;
            if (r_snooze_cnt == c_CNT_W'(1)) begin
                w_pending_nx[0] = 1'b1;
                w_snoozed_nx    = 1'b0;
            end
        end
        if (r_snoozed && w_accept[0]) w_snoozed_nx = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.btn_stop && r_snoozed) w_snoozed_nx = 1'b0;
                if (w_grant_src != c_SRC_NONE) begin
                    w_state_nx    = ST_RING;
                    w_src_nx      = w_grant_src;
                    w_buzzer_nx   = 1'b1;
                    w_tick_cnt_nx = '0;
                end
            end
            ST_RING: begin
                // Priority: stop, snooze, chime preemption, then the pattern tick.
                if (bus.btn_stop ||
                    (bus.btn_snooze && r_src == c_SRC_ALARM) ||
                    (r_src == c_SRC_CHIME && (r_pending[1:0] != 2'b00))) begin
                    w_state_nx  = ST_GAP;
                    w_buzzer_nx = 1'b0;
                    w_src_nx    = c_SRC_NONE;
                    if (!bus.btn_stop && bus.btn_snooze && r_src == c_SRC_ALARM) begin
                        w_snooze_cnt_nx = c_SNOOZE_LOAD;
                        w_snoozed_nx    = 1'b1;
                    end
                end else if (bus.tick_3hz) begin
                    if (r_tick_cnt == w_last) begin
                        w_state_nx  = ST_GAP;
                        w_buzzer_nx = 1'b0;
                        w_src_nx    = c_SRC_NONE;
                    end else begin
                        w_buzzer_nx   = ~r_buzzer;
                        w_tick_cnt_nx = r_tick_cnt + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (bus.tick_3hz) w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx  = ST_IDLE;
                w_buzzer_nx = 1'b0;
                w_src_nx    = c_SRC_NONE;
            end
        endcase
    end

    assign bus.buzzer     = r_buzzer;
    assign bus.active_src = r_src;
    assign bus.pending    = r_pending;
    assign bus.snoozed    = r_snoozed;

endmodule
`default_nettype wire

// File: tb/tb_buzzer_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_buzzer_sched
// Summary  : Directed vector table plus hand-written sequences for buzzer_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_buzzer_sched;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    buzzer_sched_if bus ();

    buzzer_sched #(
        .ALARM_SECONDS  (5),
        .TIMER_SECONDS  (5),
        .CHIME_BEEPS    (2),
        .SNOOZE_SECONDS (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       t3;
        logic       t1;
        logic [2:0] req;
        logic       stop;
        logic       snz;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Packed as {buzzer, active_src, pending, snoozed}.
    function automatic logic [6:0] E(input logic b, input logic [1:0] a,
                                     input logic [2:0] p, input logic s);
        return {b, a, p, s};
    endfunction

    function automatic logic [6:0] outs();
        return {bus.buzzer, bus.active_src, bus.pending, bus.snoozed};
    endfunction

    task automatic add(input string name, input logic t3, input logic t1,
                       input logic [2:0] req, input logic stop, input logic snz,
                       input logic [6:0] exp);
        vec_t v;
        v.name = name; v.t3 = t3; v.t1 = t1; v.req = req;
        v.stop = stop; v.snz = snz; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [6:0] exp);
        logic [6:0] act;
        act = outs();
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got {buzzer,src,pending,snoozed}=%b required %b", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses();
        bus.tick_3hz   = 1'b0;
        bus.tick_1hz   = 1'b0;
        bus.btn_stop   = 1'b0;
        bus.btn_snooze = 1'b0;
    endtask

    task automatic tick3();
        bus.tick_3hz = 1'b1;
        cyc();
        bus.tick_3hz = 1'b0;
    endtask

    task automatic tick1();
        bus.tick_1hz = 1'b1;
        cyc();
        bus.tick_1hz = 1'b0;
    endtask

    task automatic do_reset();
        bus.req_alarm = 1'b0;
        bus.req_timer = 1'b0;
        bus.req_chime = 1'b0;
        clear_pulses();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        bus.req_alarm = 1'b0;
        bus.req_timer = 1'b0;
        bus.req_chime = 1'b0;
        clear_pulses();
        cyc();
        cyc();
        check("reset_state", E(0, 2'd0, 3'b000, 0));
        reset = 1'b0;

        // Chime alone, then a timer request arriving during GAP.
        add("chime_edge",        0, 0, 3'b100, 0, 0, E(0, 2'd0, 3'b100, 0));
        add("chime_grant",       0, 0, 3'b100, 0, 0, E(1, 2'd3, 3'b000, 0));
        add("chime_hold",        0, 0, 3'b100, 0, 0, E(1, 2'd3, 3'b000, 0));
        add("chime_tick1",       1, 0, 3'b100, 0, 0, E(0, 2'd3, 3'b000, 0));
        add("chime_tick2",       1, 0, 3'b100, 0, 0, E(1, 2'd3, 3'b000, 0));
        add("chime_tick3",       1, 0, 3'b100, 0, 0, E(0, 2'd3, 3'b000, 0));
        add("chime_tick4_end",   1, 0, 3'b100, 0, 0, E(0, 2'd0, 3'b000, 0));
        add("gap_timer_req",     0, 0, 3'b110, 0, 0, E(0, 2'd0, 3'b010, 0));
        add("gap_holds",         0, 0, 3'b110, 0, 0, E(0, 2'd0, 3'b010, 0));
        add("gap_exit",          1, 0, 3'b110, 0, 0, E(0, 2'd0, 3'b010, 0));
        add("timer_grant",       0, 0, 3'b110, 0, 0, E(1, 2'd2, 3'b000, 0));
        add("timer_snz_ignored", 0, 0, 3'b110, 0, 1, E(1, 2'd2, 3'b000, 0));
        add("timer_stop_tick",   1, 0, 3'b110, 1, 0, E(0, 2'd0, 3'b000, 0));
        add("gap_exit2",         1, 0, 3'b110, 0, 0, E(0, 2'd0, 3'b000, 0));
        add("idle_quiet",        0, 0, 3'b110, 0, 0, E(0, 2'd0, 3'b000, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            bus.tick_3hz   = vecs[i].t3;
            bus.tick_1hz   = vecs[i].t1;
            bus.req_alarm  = vecs[i].req[0];
            bus.req_timer  = vecs[i].req[1];
            bus.req_chime  = vecs[i].req[2];
            bus.btn_stop   = vecs[i].stop;
            bus.btn_snooze = vecs[i].snz;
            cyc();
            clear_pulses();
            check(vecs[i].name, vecs[i].exp);
        end

        // Alarm and timer together: alarm rings 15 ticks, then timer.
        do_reset();
        bus.req_alarm = 1'b1;
        bus.req_timer = 1'b1;
        cyc();
        check("both_pending", E(0, 2'd0, 3'b011, 0));
        cyc();
        check("alarm_first", E(1, 2'd1, 3'b010, 0));
        for (int k = 1; k <= 14; k++) begin
            tick3();
            check($sformatf("alarm_tick%0d", k), E(((k % 2) == 0), 2'd1, 3'b010, 0));
        end
        tick3();
        check("alarm_end_gap", E(0, 2'd0, 3'b010, 0));
        tick3();
        cyc();
        check("timer_after_alarm", E(1, 2'd2, 3'b000, 0));

        // Chime preempted by an alarm.
        do_reset();
        bus.req_chime = 1'b1;
        cyc();
        cyc();
        check("chime2_grant", E(1, 2'd3, 3'b000, 0));
        tick3();
        tick3();
        check("chime2_two_ticks", E(1, 2'd3, 3'b000, 0));
        bus.req_alarm = 1'b1;
        cyc();
        check("preempt_pending", E(1, 2'd3, 3'b001, 0));
        cyc();
        check("chime_aborted", E(0, 2'd0, 3'b001, 0));
        tick3();
        cyc();
        check("alarm_after_abort", E(1, 2'd1, 3'b000, 0));

        // Snooze the alarm, let it expire and re-ring.
        bus.btn_snooze = 1'b1;
        cyc();
        bus.btn_snooze = 1'b0;
        check("snooze_press", E(0, 2'd0, 3'b000, 1));
        tick3();
        check("snooze_idle", E(0, 2'd0, 3'b000, 1));
        tick1();
        check("snooze_sec1", E(0, 2'd0, 3'b000, 1));
        tick1();
        check("snooze_sec2", E(0, 2'd0, 3'b000, 1));
        tick1();
        check("snooze_expire", E(0, 2'd0, 3'b001, 0));
        cyc();
        check("alarm_rering", E(1, 2'd1, 3'b000, 0));

        // Stop and snooze together: stop wins.
        bus.btn_stop   = 1'b1;
        bus.btn_snooze = 1'b1;
        cyc();
        clear_pulses();
        check("stop_beats_snooze", E(0, 2'd0, 3'b000, 0));

        // Reset mid-ring with timer and chime pending.
        do_reset();
        bus.req_alarm = 1'b1;
        cyc();
        cyc();
        check("alarm3_grant", E(1, 2'd1, 3'b000, 0));
        bus.req_alarm = 1'b0;
        cyc();
        bus.req_alarm = 1'b1;
        cyc();
        check("ringing_edge_ignored", E(1, 2'd1, 3'b000, 0));
        bus.req_timer = 1'b1;
        bus.req_chime = 1'b1;
        cyc();
        check("pending_110", E(1, 2'd1, 3'b110, 0));
        reset = 1'b1;
        cyc();
        check("reset_mid_ring", E(0, 2'd0, 3'b000, 0));
        reset = 1'b0;
        cyc();
        check("post_reset_edges", E(0, 2'd0, 3'b111, 0));
        cyc();
        check("fresh_ring", E(1, 2'd1, 3'b110, 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
